dtw_frame_feeder: RTL and testbench

Upstream input stage of the DTW accelerator. Accepts a stream of 10-bit feature components, packs each group of three into one 32-bit sample word with sequence framing flags, and buffers words in a small FIFO. It presents the words to the accelerator's Sin/valid/ready input port. It also enforces the maximum sequence length the controller can index, and reports framing errors.

---
 rtl/dtw_frame_feeder.sv | 135 +++++++++++++
 tb/tb_dtw_frame_feeder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dtw_frame_feeder.sv
// DTW input stage: packs three 10-bit feature components into framed 32-bit sample words,
// buffers them in a small FIFO and enforces the controller's maximum sequence length.
module dtw_frame_feeder #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned MAXLEN = 32
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        i_clr,
   input  logic [9:0]  i_comp,
   input  logic        i_comp_valid,
   input  logic        i_comp_first,
   input  logic        i_comp_last,
   output logic        o_comp_ready,
   output logic [31:0] o_Sin,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [5:0]  o_vec_cnt,
   output logic        o_err
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {StC0, StC1, StC2} state_e;

   state_e        r_state;
   logic [9:0]    r_c0, r_c1;
   logic          r_first, r_drop, r_err;
   logic [5:0]    r_vec_cnt;
   logic [PW-1:0] r_wptr, r_rptr;
   logic [CW-1:0] r_count;
   logic [31:0]   r_sin;
   logic [31:0]   r_mem [DEPTH];

   logic          w_acc, w_done, w_push, w_pop, w_hit;
   logic [5:0]    w_cnt_inc;
   logic [31:0]   w_word, w_head_nxt;
   logic [CW-1:0] w_count_nxt;
   logic [PW-1:0] w_rptr_nxt;

   assign o_comp_ready = (r_state != StC2) || (r_count < CW'(DEPTH));
   assign o_valid      = (r_count != '0);
   assign o_Sin        = r_sin;
   assign o_vec_cnt    = r_vec_cnt;
   assign o_err        = r_err;

   assign w_acc  = i_comp_valid && o_comp_ready;
   // A first flag on c1/c2 restarts the vector instead of completing it.
   assign w_done = w_acc && (r_state == StC2) && !i_comp_first;
   assign w_push = w_done && !r_drop;
   assign w_pop  = o_valid && i_ready;

   assign w_cnt_inc = r_first ? 6'd1 :
                      (r_vec_cnt >= 6'(MAXLEN)) ? 6'(MAXLEN) : r_vec_cnt + 6'd1;
   assign w_hit     = (w_cnt_inc == 6'(MAXLEN));
   assign w_word    = {r_first, i_comp_last | w_hit, r_c0, r_c1, i_comp};

   assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
   assign w_rptr_nxt  = r_rptr + PW'(w_pop);

   // Bypass the pushed word when it lands directly in the new head slot.
   always_comb begin
      w_head_nxt = '0;
      if (w_count_nxt != '0) begin
         if (w_push && (r_wptr == w_rptr_nxt)) w_head_nxt = w_word;
         else                                  w_head_nxt = r_mem[w_rptr_nxt];
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !i_clr) r_mem[r_wptr] <= w_word;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state   <= StC0;
         r_c0      <= '0;
         r_c1      <= '0;
         r_first   <= 1'b0;
         r_drop    <= 1'b0;
         r_err     <= 1'b0;
         r_vec_cnt <= '0;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_sin     <= '0;
      end else if (i_clr) begin
         r_state   <= StC0;
         r_first   <= 1'b0;
         r_drop    <= 1'b0;
         r_err     <= 1'b0;
         r_vec_cnt <= '0;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_sin     <= '0;
      end else begin
         if (w_acc) begin
            if (i_comp_first) begin
               r_c0    <= i_comp;
               r_first <= 1'b1;
               r_drop  <= 1'b0;
               r_state <= StC1;
               if (r_state != StC0) r_err <= 1'b1;
            end else begin
               case (r_state)
                  StC0: begin
                     r_c0    <= i_comp;
                     r_first <= 1'b0;
                     r_state <= StC1;
                  end
                  StC1: begin
                     r_c1    <= i_comp;
                     r_state <= StC2;
                  end
                  default: r_state <= StC0;
               endcase
            end
         end
         if (w_push) begin
            r_vec_cnt <= w_cnt_inc;
            r_wptr    <= r_wptr + PW'(1);
            if (w_hit && !i_comp_last) begin
               r_drop <= 1'b1;
               r_err  <= 1'b1;
            end
         end
         r_rptr  <= w_rptr_nxt;
         r_count <= w_count_nxt;
         r_sin   <= w_head_nxt;
      end
   end

endmodule

// File: tb/tb_dtw_frame_feeder.sv
// Directed bench for dtw_frame_feeder: packing, backpressure, framing, length limit and flushes.
module tb_dtw_frame_feeder;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        i_clr = 1'b0;
   logic [9:0]  i_comp = '0;
   logic        i_comp_valid = 1'b0;
   logic        i_comp_first = 1'b0;
   logic        i_comp_last = 1'b0;
   logic        o_comp_ready;
   logic [31:0] o_Sin;
   logic        o_valid;
   logic        i_ready = 1'b0;
   logic [5:0]  o_vec_cnt;
   logic        o_err;

   int n_checks = 0;
   int n_errs   = 0;
   logic [31:0] rx_q [$];

   dtw_frame_feeder #(.DEPTH(4), .MAXLEN(32)) dut (
      .clk          (clk),
      .nrst         (nrst),
      .i_clr        (i_clr),
      .i_comp       (i_comp),
      .i_comp_valid (i_comp_valid),
      .i_comp_first (i_comp_first),
      .i_comp_last  (i_comp_last),
      .o_comp_ready (o_comp_ready),
      .o_Sin        (o_Sin),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_vec_cnt    (o_vec_cnt),
      .o_err        (o_err)
   );

   always #5 clk = ~clk;

   // Capture every word handed downstream.
   always @(posedge clk) begin
      if (nrst && !i_clr && o_valid && i_ready) rx_q.push_back(o_Sin);
   end

   function automatic logic [31:0] mkw(input logic f, input logic l, input logic [9:0] a,
                                       input logic [9:0] b, input logic [9:0] c);
      return {f, l, a, b, c};
   endfunction

   // Called at a negedge; returns at the negedge after the component is accepted.
   task automatic send_comp(input logic [9:0] c, input logic f, input logic l);
      int t;
      i_comp = c; i_comp_first = f; i_comp_last = l; i_comp_valid = 1'b1;
      t = 0;
      while (!o_comp_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         n_checks++; n_errs++;
         $display("FAIL send_timeout: o_comp_ready=%b required 1", o_comp_ready);
      end
      @(negedge clk);
      i_comp_valid = 1'b0; i_comp_first = 1'b0; i_comp_last = 1'b0;
   endtask

   task automatic send_vec(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c,
                           input logic f, input logic l);
      send_comp(a, f, 1'b0);
      send_comp(b, 1'b0, 1'b0);
      send_comp(c, 1'b0, l);
   endtask

   task automatic wait_rx(input int n);
      int t;
      t = 0;
      while (rx_q.size() < n && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) begin
         n_checks++; n_errs++;
         $display("FAIL rx_timeout: got %0d words required %0d", rx_q.size(), n);
      end
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (o_valid !== 1'b0) begin n_errs++; $display("FAIL rst_valid: got %b required 0", o_valid); end
      n_checks++; if (o_Sin !== 32'h0) begin n_errs++; $display("FAIL rst_sin: got %h required 0", o_Sin); end
      n_checks++; if (o_comp_ready !== 1'b1) begin n_errs++; $display("FAIL rst_ready: got %b required 1", o_comp_ready); end
      n_checks++; if (o_vec_cnt !== 6'd0) begin n_errs++; $display("FAIL rst_cnt: got %0d required 0", o_vec_cnt); end
      n_checks++; if (o_err !== 1'b0) begin n_errs++; $display("FAIL rst_err: got %b required 0", o_err); end
      nrst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      rx_q.delete();
      i_ready = 1'b1;
      send_vec(10'h3FF, 10'h001, 10'h155, 1'b1, 1'b1);
      n_checks++; if (o_valid !== 1'b1) begin n_errs++; $display("FAIL basic_valid: got %b required 1", o_valid); end
      n_checks++; if (o_Sin !== 32'hFFF00555) begin n_errs++; $display("FAIL basic_sin: got %h required fff00555", o_Sin); end
      n_checks++; if (o_vec_cnt !== 6'd1) begin n_errs++; $display("FAIL basic_cnt: got %0d required 1", o_vec_cnt); end
      @(negedge clk);
      n_checks++; if (o_valid !== 1'b0) begin n_errs++; $display("FAIL basic_drop: got %b required 0", o_valid); end
      n_checks++; if (rx_q.size() !== 1) begin n_errs++; $display("FAIL basic_rxn: got %0d required 1", rx_q.size()); end
   endtask

   task automatic test_backpressure();
      rx_q.delete();
      i_ready = 1'b0;
      for (int k = 0; k < 4; k++)
         send_vec(10'h100 + 10'(k), 10'h200 + 10'(k), 10'h300 + 10'(k), k == 0, 1'b0);
      n_checks++; if (o_comp_ready !== 1'b1) begin n_errs++; $display("FAIL bp_ready_c0: got %b required 1", o_comp_ready); end
      n_checks++; if (o_Sin !== mkw(1, 0, 10'h100, 10'h200, 10'h300)) begin n_errs++; $display("FAIL bp_hold: got %h required %h", o_Sin, mkw(1, 0, 10'h100, 10'h200, 10'h300)); end
      send_comp(10'h104, 1'b0, 1'b0);
      send_comp(10'h204, 1'b0, 1'b0);
      i_comp = 10'h304; i_comp_last = 1'b1; i_comp_valid = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (o_comp_ready !== 1'b0) begin n_errs++; $display("FAIL bp_ready_c2: got %b required 0", o_comp_ready); end
      n_checks++; if (o_vec_cnt !== 6'd4) begin n_errs++; $display("FAIL bp_cnt4: got %0d required 4", o_vec_cnt); end
      i_ready = 1'b1;
      send_comp(10'h304, 1'b0, 1'b1);
      wait_rx(5);
      for (int k = 0; k < 5; k++) begin
         n_checks++;
         if (rx_q.size() <= k || rx_q[k] !== mkw(k == 0, k == 4, 10'h100 + 10'(k), 10'h200 + 10'(k), 10'h300 + 10'(k))) begin
            n_errs++; $display("FAIL bp_word%0d: got %h required %h", k, (rx_q.size() > k) ? rx_q[k] : 32'hx,
                               mkw(k == 0, k == 4, 10'h100 + 10'(k), 10'h200 + 10'(k), 10'h300 + 10'(k)));
         end
      end
      n_checks++; if (o_vec_cnt !== 6'd5) begin n_errs++; $display("FAIL bp_cnt5: got %0d required 5", o_vec_cnt); end
   endtask

   task automatic test_back_to_back();
      rx_q.delete();
      i_ready = 1'b1;
      for (int k = 0; k < 6; k++)
         send_vec(10'h0A0 + 10'(k), 10'h150 + 10'(k), 10'h2C0 + 10'(k), k == 0, k == 5);
      wait_rx(6);
      repeat (2) @(negedge clk);
      n_checks++; if (rx_q.size() !== 6) begin n_errs++; $display("FAIL b2b_n: got %0d required 6", rx_q.size()); end
      for (int k = 0; k < 6; k++) begin
         n_checks++;
         if (rx_q.size() <= k || rx_q[k] !== mkw(k == 0, k == 5, 10'h0A0 + 10'(k), 10'h150 + 10'(k), 10'h2C0 + 10'(k))) begin
            n_errs++; $display("FAIL b2b_word%0d: got %h", k, (rx_q.size() > k) ? rx_q[k] : 32'hx);
         end
      end
   endtask

   task automatic test_framing();
      rx_q.delete();
      i_ready = 1'b1;
      send_comp(10'h010, 1'b1, 1'b0);
      send_comp(10'h020, 1'b0, 1'b0);
      n_checks++; if (o_err !== 1'b0) begin n_errs++; $display("FAIL frm_err0: got %b required 0", o_err); end
      send_comp(10'h030, 1'b1, 1'b0);
      n_checks++; if (o_err !== 1'b1) begin n_errs++; $display("FAIL frm_err1: got %b required 1", o_err); end
      send_comp(10'h040, 1'b0, 1'b0);
      send_comp(10'h050, 1'b0, 1'b0);
      n_checks++; if (o_Sin !== 32'h83010050) begin n_errs++; $display("FAIL frm_sin: got %h required 83010050", o_Sin); end
      n_checks++; if (o_vec_cnt !== 6'd1) begin n_errs++; $display("FAIL frm_cnt: got %0d required 1", o_vec_cnt); end
      repeat (2) @(negedge clk);
      n_checks++; if (rx_q.size() !== 1) begin n_errs++; $display("FAIL frm_rxn: got %0d required 1", rx_q.size()); end
   endtask

   task automatic test_overflow();
      i_clr = 1'b1;
      @(negedge clk);
      i_clr = 1'b0;
      n_checks++; if (o_err !== 1'b0) begin n_errs++; $display("FAIL ovf_clr_err: got %b required 0", o_err); end
      rx_q.delete();
      i_ready = 1'b1;
      for (int k = 1; k <= 34; k++) begin
         send_vec(10'(k), 10'h000, 10'(k), k == 1, 1'b0);
         if (k == 31) begin
            n_checks++; if (o_err !== 1'b0) begin n_errs++; $display("FAIL ovf_err31: got %b required 0", o_err); end
         end
         if (k == 32) begin
            n_checks++; if (o_err !== 1'b1) begin n_errs++; $display("FAIL ovf_err32: got %b required 1", o_err); end
            n_checks++; if (o_Sin !== mkw(0, 1, 10'd32, 10'd0, 10'd32)) begin n_errs++; $display("FAIL ovf_sin32: got %h required %h", o_Sin, mkw(0, 1, 10'd32, 10'd0, 10'd32)); end
         end
      end
      repeat (3) @(negedge clk);
      n_checks++; if (rx_q.size() !== 32) begin n_errs++; $display("FAIL ovf_rxn: got %0d required 32", rx_q.size()); end
      n_checks++; if (o_vec_cnt !== 6'd32) begin n_errs++; $display("FAIL ovf_cnt: got %0d required 32", o_vec_cnt); end
      n_checks++; if (rx_q.size() > 0 && rx_q[0] !== mkw(1, 0, 10'd1, 10'd0, 10'd1)) begin n_errs++; $display("FAIL ovf_w1: got %h", rx_q[0]); end
      send_vec(10'h3A5, 10'h05A, 10'h1C3, 1'b1, 1'b1);
      n_checks++; if (o_Sin !== mkw(1, 1, 10'h3A5, 10'h05A, 10'h1C3)) begin n_errs++; $display("FAIL ovf_next_sin: got %h", o_Sin); end
      n_checks++; if (o_vec_cnt !== 6'd1) begin n_errs++; $display("FAIL ovf_next_cnt: got %0d required 1", o_vec_cnt); end
      n_checks++; if (o_err !== 1'b1) begin n_errs++; $display("FAIL ovf_sticky: got %b required 1", o_err); end
      repeat (2) @(negedge clk);
   endtask

   task automatic load_two_and_c2();
      i_ready = 1'b0;
      send_vec(10'h001, 10'h002, 10'h003, 1'b1, 1'b0);
      send_vec(10'h004, 10'h005, 10'h006, 1'b0, 1'b0);
      send_comp(10'h007, 1'b0, 1'b0);
      send_comp(10'h008, 1'b0, 1'b0);
   endtask

   task automatic refill_check(input string nm);
      int n0;
      i_ready = 1'b1;
      n0 = rx_q.size();
      send_comp(10'h011, 1'b0, 1'b0);
      send_comp(10'h022, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      n_checks++; if (o_valid !== 1'b0 || rx_q.size() !== n0) begin n_errs++; $display("FAIL %s_quiet: valid=%b words=%0d required 0", nm, o_valid, rx_q.size() - n0); end
      send_comp(10'h033, 1'b0, 1'b1);
      n_checks++; if (o_Sin !== mkw(0, 1, 10'h011, 10'h022, 10'h033) || o_valid !== 1'b1) begin n_errs++; $display("FAIL %s_word: got %h valid=%b required %h", nm, o_Sin, o_valid, mkw(0, 1, 10'h011, 10'h022, 10'h033)); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_async_reset();
      load_two_and_c2();
      n_checks++; if (o_valid !== 1'b1 || o_comp_ready !== 1'b1) begin n_errs++; $display("FAIL ar_pre: valid=%b ready=%b required 1 1", o_valid, o_comp_ready); end
      #2 nrst = 1'b0;
      #1;
      n_checks++; if (o_valid !== 1'b0 || o_comp_ready !== 1'b1 || o_Sin !== 32'h0) begin n_errs++; $display("FAIL ar_now: valid=%b ready=%b sin=%h required 0 1 0", o_valid, o_comp_ready, o_Sin); end
      n_checks++; if (o_err !== 1'b0 || o_vec_cnt !== 6'd0) begin n_errs++; $display("FAIL ar_state: err=%b cnt=%0d required 0 0", o_err, o_vec_cnt); end
      @(negedge clk);
      nrst = 1'b1;
      refill_check("ar");
   endtask

   task automatic test_clr_flush();
      send_comp(10'h015, 1'b1, 1'b0);
      send_comp(10'h016, 1'b1, 1'b0);
      load_two_and_c2();
      n_checks++; if (o_err !== 1'b1 || o_comp_ready !== 1'b1) begin n_errs++; $display("FAIL clr_pre: err=%b ready=%b required 1 1", o_err, o_comp_ready); end
      i_clr = 1'b1;
      #1;
      n_checks++; if (o_valid !== 1'b1) begin n_errs++; $display("FAIL clr_early: valid=%b required 1", o_valid); end
      @(negedge clk);
      i_clr = 1'b0;
      n_checks++; if (o_valid !== 1'b0 || o_comp_ready !== 1'b1 || o_Sin !== 32'h0) begin n_errs++; $display("FAIL clr_after: valid=%b ready=%b sin=%h required 0 1 0", o_valid, o_comp_ready, o_Sin); end
      n_checks++; if (o_err !== 1'b0 || o_vec_cnt !== 6'd0) begin n_errs++; $display("FAIL clr_state: err=%b cnt=%0d required 0 0", o_err, o_vec_cnt); end
      refill_check("clr");
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_framing();
      test_overflow();
      test_async_reset();
      test_clr_flush();
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
